// File: rtl/pc_sequencer.sv
// Program sequencer: drives the instruction-memory address, holds it on delay
// instructions, and supports absolute jumps plus a bounded call/return stack.
module pc_sequencer #(
  parameter int AW    = 8,
  parameter int CW    = 32,
  parameter int DEPTH = 4,
  localparam int SW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt,
  input  logic          jump,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] target,
  input  logic          delay_req,
  input  logic [CW-1:0] delay_cycles,
  output logic [AW-1:0] pc_out,
  output logic          busy,
  output logic [SW-1:0] depth,
  output logic          fault,
  output logic [1:0]    fault_code
);

  // state   | meaning
  // S_RUN   | normal sequencing, one control request honoured per edge
  // S_WAIT  | pc held while the delay down-counter runs to terminal count
  // S_FAULT | stack over/underflow seen; everything frozen until reset
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SW-1:0] DEPTH_MAX = SW'(DEPTH);

  state_t        state;
  logic [CW-1:0] count;
  logic [AW-1:0] stack_mem [2**IW];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          push;

  assign wr_idx  = IW'(depth);
  assign top_idx = IW'(depth - SW'(1));
  assign push    = rst_n && !halt && (state == S_RUN) && !ret && call &&
                   (depth != DEPTH_MAX);

  // Entries above depth are don't-care, so the stack array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[wr_idx] <= pc_out + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      pc_out     <= '0;
      count      <= '0;
      depth      <= '0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else if (!halt) begin
      case (state)
        S_RUN: begin
          if (ret) begin
            if (depth == '0) begin
              state      <= S_FAULT;
              fault      <= 1'b1;
              fault_code <= 2'b10;
            end else begin
              pc_out <= stack_mem[top_idx];
              depth  <= depth - SW'(1);
            end
          end else if (call) begin
            if (depth == DEPTH_MAX) begin
              state      <= S_FAULT;
              fault      <= 1'b1;
              fault_code <= 2'b01;
            end else begin
              pc_out <= target;
              depth  <= depth + SW'(1);
            end
          end else if (jump) begin
            pc_out <= target;
          end else if (delay_req && (delay_cycles != '0)) begin
            count <= delay_cycles - CW'(1);
            busy  <= 1'b1;
            state <= S_WAIT;
          end else begin
            pc_out <= pc_out + AW'(1);
          end
        end
        S_WAIT: begin
          if (count == '0) begin
            pc_out <= pc_out + AW'(1);
            busy   <= 1'b0;
            state  <= S_RUN;
          end else begin
            count <= count - CW'(1);
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state <= S_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random control traffic,
// each edge compared against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int AW = 8;
  localparam int CW = 32;
  localparam int DEPTH = 4;
  localparam int SW = $clog2(DEPTH + 1);
  localparam int PC_MOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          halt = 1'b0;
  logic          jump = 1'b0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic [AW-1:0] target = '0;
  logic          delay_req = 1'b0;
  logic [CW-1:0] delay_cycles = '0;
  logic [AW-1:0] pc_out;
  logic          busy;
  logic [SW-1:0] depth;
  logic          fault;
  logic [1:0]    fault_code;

  pc_sequencer #(.AW(AW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .jump(jump), .call(call),
    .ret(ret), .target(target), .delay_req(delay_req),
    .delay_cycles(delay_cycles), .pc_out(pc_out), .busy(busy),
    .depth(depth), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string phase = "init";

  // Reference model: address, LIFO of return addresses, remaining hold edges.
  int m_pc;
  int m_stack[$];
  int m_hold;
  bit m_fault;
  int m_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("pc_out", 32'(pc_out), m_pc);
    chk("busy", 32'(busy), (m_hold > 0) ? 1 : 0);
    chk("depth", 32'(depth), m_stack.size());
    chk("fault", 32'(fault), m_fault ? 1 : 0);
    chk("fault_code", 32'(fault_code), m_code);
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_hold = 0;
    m_fault = 0;
    m_code = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs held across it.
  task automatic model_edge();
    if (halt || m_fault) return;
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_pc = (m_pc + 1) % PC_MOD;
    end else if (ret) begin
      if (m_stack.size() == 0) begin
        m_fault = 1;
        m_code = 2;
      end else begin
        m_pc = m_stack.pop_back();
      end
    end else if (call) begin
      if (m_stack.size() == DEPTH) begin
        m_fault = 1;
        m_code = 1;
      end else begin
        m_stack.push_back((m_pc + 1) % PC_MOD);
        m_pc = int'(target);
      end
    end else if (jump) begin
      m_pc = int'(target);
    end else if (delay_req && delay_cycles != 0) begin
      m_hold = int'(delay_cycles);
    end else begin
      m_pc = (m_pc + 1) % PC_MOD;
    end
  endtask

  task automatic clear_inputs();
    halt = 0; jump = 0; call = 0; ret = 0; delay_req = 0;
    target = '0; delay_cycles = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset is asserted between edges and checked before the next edge arrives.
  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    #2;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic do_jump(input int t);
    clear_inputs(); jump = 1; target = AW'(t); tick(); clear_inputs();
  endtask

  task automatic do_call(input int t);
    clear_inputs(); call = 1; target = AW'(t); tick(); clear_inputs();
  endtask

  task automatic do_ret();
    clear_inputs(); ret = 1; tick(); clear_inputs();
  endtask

  task automatic do_delay(input int n);
    clear_inputs(); delay_req = 1; delay_cycles = CW'(n); tick(); clear_inputs();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    model_reset();
    #12;
    phase = "reset";
    do_reset();

    phase = "increment";
    idle(255);
    chk("pc_at_255", 32'(pc_out), 255);
    idle(1);
    chk("wrap_to_0", 32'(pc_out), 0);
    idle(4);

    phase = "delay3";
    do_reset();
    do_jump(5);
    do_delay(3);
    chk("held_pc", 32'(pc_out), 5);
    idle(2);
    chk("still_held", 32'(pc_out), 5);
    idle(1);
    chk("released", 32'(pc_out), 6);
    idle(1);

    phase = "delay0";
    do_jump(9);
    do_delay(0);
    chk("n0_pc", 32'(pc_out), 10);
    idle(2);

    phase = "halt_delay";
    do_jump(20);
    do_delay(4);
    idle(1);
    clear_inputs(); halt = 1; tick(); tick();
    clear_inputs(); halt = 1; jump = 1; target = 8'hEE; tick();
    idle(6);

    phase = "halt_run";
    clear_inputs(); halt = 1; call = 1; target = 8'h33;
    for (int i = 0; i < 3; i++) tick();
    idle(1);

    phase = "nesting";
    do_reset();
    do_jump(8'h10);
    do_call(8'h40);
    idle(1);
    do_call(8'h80);
    do_ret();
    chk("ret1_pc", 32'(pc_out), 8'h42);
    do_ret();
    chk("ret2_pc", 32'(pc_out), 8'h11);
    idle(2);

    phase = "overflow";
    for (int i = 0; i < 5; i++) do_call(8'h20 + i);
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_code", 32'(fault_code), 1);
    do_ret();
    do_jump(8'h77);
    do_delay(2);
    idle(3);
    phase = "ovf_reset";
    @(posedge clk); #3;
    do_reset();
    idle(2);

    phase = "underflow";
    do_ret();
    chk("udf_code", 32'(fault_code), 2);
    idle(3);
    do_reset();

    phase = "priority";
    do_jump(8'h30);
    do_call(8'h50);
    idle(1);
    clear_inputs(); ret = 1; call = 1; jump = 1; target = 8'h99; tick();
    chk("ret_wins", 32'(pc_out), 8'h31);
    clear_inputs(); jump = 1; delay_req = 1; delay_cycles = 5; target = 8'h60; tick();
    chk("jump_no_wait", 32'(busy), 0);
    idle(2);

    phase = "wait_ignores";
    do_delay(3);
    clear_inputs(); ret = 1; call = 1; jump = 1; target = 8'h01; tick();
    clear_inputs(); delay_req = 1; delay_cycles = 7; tick();
    idle(3);

    phase = "random";
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if (m_fault && $urandom_range(0, 9) == 0) begin
        do_reset();
      end else begin
        clear_inputs();
        halt         = ($urandom_range(0, 99) < 10);
        ret          = ($urandom_range(0, 99) < 8);
        call         = ($urandom_range(0, 99) < 10);
        jump         = ($urandom_range(0, 99) < 8);
        delay_req    = ($urandom_range(0, 99) < 12);
        target       = AW'($urandom);
        delay_cycles = CW'($urandom_range(0, 6));
        tick();
      end
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
